// File: rtl/ps2_pkg.sv
// Shared PS/2 frame constants and scan-code prefixes used by the receiver
// and by downstream scan-code decoders.
package ps2_pkg;
  localparam int FRAME_BITS = 11;
  localparam logic [7:0] BREAK_PREFIX = 8'hF0;
  localparam logic [7:0] EXT_PREFIX   = 8'hE0;

  // Frame layout, LSB first: start, d0..d7, odd parity, stop.
  function automatic logic frame_ok(input logic [FRAME_BITS-1:0] f);
    return (f[0] == 1'b0) && (f[FRAME_BITS-1] == 1'b1) && (^f[9:1] == 1'b1);
  endfunction
endpackage

// File: rtl/ps2_fifo.sv
// Small receive FIFO for scan codes: pointer + occupancy, head always visible,
// sticky overflow that clears on the next successful pop.
module ps2_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head_data,
  output logic       full,
  output logic       empty,
  output logic       overflow
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wptr_reg;
  logic [PW-1:0] rptr_reg;
  logic [CW-1:0] count_reg;
  logic          overflow_reg;
  logic          push_ok;
  logic          pop_ok;

  assign full     = (count_reg == CW'(DEPTH));
  assign empty    = (count_reg == '0);
  assign pop_ok   = pop & ~empty;
  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign push_ok  = push & (~full | pop_ok);
  assign overflow = overflow_reg;
  assign head_data = empty ? 8'h00 : mem[rptr_reg];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wptr_reg     <= '0;
      rptr_reg     <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) wptr_reg <= wptr_reg + 1'b1;
      if (pop_ok)  rptr_reg <= rptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (pop_ok)
        overflow_reg <= 1'b0;
      else if (push & full)
        overflow_reg <= 1'b1;
    end
  end
endmodule

// File: rtl/ps2_kbd_receiver.sv
// PS/2 keyboard receiver: synchronizes the keyboard lines, assembles 11-bit
// frames on falling ps2_clk, validates them and queues good scan codes.
module ps2_kbd_receiver
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // [0],[1] synchronizer stages, [2] history for edge detection
  logic [2:0]            clk_sync_reg;
  logic [1:0]            dat_sync_reg;
  logic [3:0]            bit_cnt_reg;
  logic [FRAME_BITS-1:0] frame_reg;
  logic [FRAME_BITS-1:0] frame_next;
  logic [TW-1:0]         idle_cnt_reg;
  logic                  push_reg;
  logic [7:0]            push_byte_reg;
  logic                  frame_err_reg;
  logic                  sample_evt;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  pop;

  assign sample_evt = clk_sync_reg[2] & ~clk_sync_reg[1];
  assign frame_next = {dat_sync_reg[1], frame_reg[FRAME_BITS-1:1]};
  assign frame_err  = frame_err_reg;
  assign ready      = ~fifo_empty;
  assign pop        = ~nextdata_n & ready;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync_reg  <= 3'b111;
      dat_sync_reg  <= 2'b11;
      bit_cnt_reg   <= '0;
      frame_reg     <= '0;
      idle_cnt_reg  <= '0;
      push_reg      <= 1'b0;
      push_byte_reg <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[1:0], ps2_clk};
      dat_sync_reg  <= {dat_sync_reg[0], ps2_data};
      push_reg      <= 1'b0;
      frame_err_reg <= 1'b0;
      if (sample_evt) begin
        frame_reg    <= frame_next;
        idle_cnt_reg <= '0;
        if (bit_cnt_reg == 4'd10) begin
          bit_cnt_reg <= '0;
          if (frame_ok(frame_next)) begin
            push_reg      <= 1'b1;
            push_byte_reg <= frame_next[8:1];
          end else begin
            frame_err_reg <= 1'b1;
          end
        end else begin
          bit_cnt_reg <= bit_cnt_reg + 1'b1;
        end
      end else if (bit_cnt_reg != 4'd0) begin
        // A keyboard that stalls mid-frame must not wedge the bit counter.
        if (idle_cnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
          bit_cnt_reg   <= '0;
          idle_cnt_reg  <= '0;
          frame_err_reg <= 1'b1;
        end else begin
          idle_cnt_reg <= idle_cnt_reg + 1'b1;
        end
      end
    end
  end

  ps2_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .clrn     (clrn),
    .push     (push_reg),
    .push_data(push_byte_reg),
    .pop      (pop),
    .head_data(data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .overflow (overflow)
  );

  logic unused_full;
  assign unused_full = fifo_full;
endmodule

// File: tb/tb_ps2_kbd_receiver.sv
// Directed bench for ps2_kbd_receiver: table of single frames plus hand-written
// sequences for queueing, overflow, timeout and mid-frame reset.
module tb_ps2_kbd_receiver;
  logic       clk = 1'b0;
  logic       clrn;
  logic       ps2_clk;
  logic       ps2_data;
  logic       nextdata_n;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  int tests = 0;
  int fails = 0;
  int err_cnt = 0;

  typedef struct {
    logic [7:0] code;
    bit         bad_par;
    bit         bad_stop;
    bit         exp_ready;
    int         exp_err;
  } vec_t;

  vec_t vecs[6];

  ps2_kbd_receiver dut (
    .clk       (clk),
    .clrn      (clrn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .nextdata_n(nextdata_n),
    .data      (data),
    .ready     (ready),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_err === 1'b1) err_cnt <= err_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int half, input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (half) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (half) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pop_one();
    @(negedge clk) nextdata_n = 1'b0;
    @(negedge clk) nextdata_n = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    vecs[0] = '{8'h15, 1'b0, 1'b0, 1'b1, 0};
    vecs[1] = '{8'h15, 1'b1, 1'b0, 1'b0, 1};
    vecs[2] = '{8'h1C, 1'b0, 1'b0, 1'b1, 0};
    vecs[3] = '{8'hA5, 1'b0, 1'b0, 1'b1, 0};
    vecs[4] = '{8'h00, 1'b0, 1'b0, 1'b1, 0};
    vecs[5] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1};

    clrn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; nextdata_n = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_ready", {31'd0, ready}, 0);
    check("reset_data", {24'd0, data}, 32'h00);
    check("reset_overflow", {31'd0, overflow}, 0);
    check("reset_frame_err", {31'd0, frame_err}, 0);
    clrn = 1'b1;
    repeat (5) @(negedge clk);

    // Single-frame table: first entry at the nominal 2000-clk bit period.
    for (int i = 0; i < 6; i++) begin
      e0 = err_cnt;
      send_frame(vecs[i].code, vecs[i].bad_par, vecs[i].bad_stop, (i == 0) ? 1000 : 100, 11);
      check($sformatf("vec%0d_ready", i), {31'd0, ready}, {31'd0, vecs[i].exp_ready});
      if (vecs[i].exp_ready) check($sformatf("vec%0d_data", i), {24'd0, data}, {24'd0, vecs[i].code});
      check($sformatf("vec%0d_err_pulses", i), err_cnt - e0, vecs[i].exp_err);
      if (ready) begin
        pop_one();
        @(negedge clk);
        check($sformatf("vec%0d_ready_after_pop", i), {31'd0, ready}, 0);
      end
    end

    // Break sequence F0 15 queued, then drained.
    send_frame(8'hF0, 1'b0, 1'b0, 100, 11);
    send_frame(8'h15, 1'b0, 1'b0, 100, 11);
    check("seq_head_f0", {24'd0, data}, 32'hF0);
    pop_one();
    check("seq_head_15", {24'd0, data}, 32'h15);
    pop_one();
    check("seq_empty", {31'd0, ready}, 0);

    // Nine frames into an 8-deep FIFO.
    for (int k = 1; k <= 9; k++) send_frame(8'(k), 1'b0, 1'b0, 100, 11);
    check("ovf_set", {31'd0, overflow}, 1);
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("ovf_pop%0d_data", k), {24'd0, data}, k);
      pop_one();
      if (k == 1) check("ovf_cleared", {31'd0, overflow}, 0);
    end
    check("ovf_drained", {31'd0, ready}, 0);

    // Stalled frame abandoned by timeout, then a good frame.
    e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b0, 100, 5);
    repeat (5200) @(negedge clk);
    check("timeout_err_pulses", err_cnt - e0, 1);
    check("timeout_no_data", {31'd0, ready}, 0);
    send_frame(8'h1C, 1'b0, 1'b0, 100, 11);
    check("after_timeout_ready", {31'd0, ready}, 1);
    check("after_timeout_data", {24'd0, data}, 32'h1C);
    check("after_timeout_no_err", err_cnt - e0, 1);
    pop_one();

    // Reset in the middle of a frame.
    send_frame(8'h24, 1'b0, 1'b0, 100, 4);
    @(negedge clk) clrn = 1'b0;
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    e0 = err_cnt;
    send_frame(8'h24, 1'b0, 1'b0, 100, 11);
    check("rst_mid_ready", {31'd0, ready}, 1);
    check("rst_mid_data", {24'd0, data}, 32'h24);
    check("rst_mid_overflow", {31'd0, overflow}, 0);
    check("rst_mid_no_err", err_cnt - e0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ps2_kbd_receiver.md
PS2_KBD_RECEIVER -- requirements
Module: ps2_kbd_receiver

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, receive-FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 5000, idle clk cycles mid-frame before the frame is abandoned.
REQ-003 SHALL have port clk  input  1  single system clock; all state on its rising edge.
REQ-004 SHALL have port clrn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ps2_clk  input  1  raw PS/2 clock from keyboard, asynchronous to clk.
REQ-006 SHALL have port ps2_data  input  1  raw PS/2 data, asynchronous to clk.
REQ-007 SHALL have port nextdata_n  input  1  active-low pop strobe, one entry per asserted cycle.
REQ-008 SHALL have port data  output  8  scan code at FIFO head, feeding the scancode-to-ASCII lookup.
REQ-009 SHALL have port ready  output  1  high when FIFO non-empty.
REQ-010 SHALL have port overflow  output  1  sticky: a valid frame was dropped because the FIFO was full.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse on a rejected frame (start/stop/parity/timeout).

Function
REQ-012 SHALL pass ps2_clk and ps2_data through 2-flop synchronizers plus one history flop; sample event = synchronized ps2_clk falling (previous 1, current 0).
REQ-013 SHALL run a 4-bit bit counter 0..10; each sample event shifts synchronized ps2_data into an 11-bit frame register LSB-first (start, d0..d7, parity, stop).
REQ-014 SHALL, on the sample event at count 10, check start==0, stop==1, XOR of d0..d7 and parity ==1 (odd); counter returns to 0 on the same cycle.
REQ-015 SHALL push d0..d7 into the FIFO in the cycle after a passing check; a failing check SHALL push nothing and pulse frame_err.
REQ-016 SHALL count clk cycles since the last sample event while counter !=0; reaching TIMEOUT_CYCLES SHALL reset the counter to 0 and pulse frame_err once.
REQ-017 SHALL present data = FIFO[rptr] and ready = (count != 0), both valid from the cycle after the push (push-to-ready latency 1 cycle after the checking sample event's register update).
REQ-018 Pop: nextdata_n==0 and ready==1 advances rptr; pop while empty SHALL be ignored with no state change.
REQ-019 Push while full without simultaneous pop SHALL drop the byte and set overflow; push and pop in the same cycle when full SHALL both succeed, occupancy unchanged.
REQ-020 Simultaneous push and pop when non-full SHALL leave occupancy unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-021 overflow SHALL clear only on a successful pop or reset.
REQ-022 data contents when ready==0 are don't-care; consumers SHALL qualify with ready.

Reset
REQ-023 clrn low SHALL asynchronously clear synchronizers to 1, counter, timeout counter, frame register, pointers and occupancy to 0; outputs ready=0, overflow=0, frame_err=0, data=8'h00.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame; the next frame after release SHALL be received normally.

Structure
REQ-025 Package ps2_pkg SHALL hold FRAME_BITS=11, scan-code constants BREAK_PREFIX=8'hF0 and EXT_PREFIX=8'hE0 for downstream decoders.
REQ-026 FIFO SHALL be a separate sub-module ps2_fifo (depth-parameterized, pointer + occupancy, push/pop/full/empty); frame reception stays in the top.

Verification
REQ-027 Frame 0x15 (bits 0,1,0,1,0,1,0,0,0,0,1), ps2 bit period 2000 clk -> ready=1, data=8'h15, no frame_err; pop -> ready=0.
REQ-028 Frames F0 then 15 without pops -> data=F0; pop -> data=15; pop -> ready=0.
REQ-029 Frame 0x15 with parity bit 1 -> frame_err one pulse, ready stays 0.
REQ-030 Nine valid frames 0x01..0x09, no pops, depth 8 -> overflow=1, pops return 01..08, overflow clears at first pop.
REQ-031 Stop after 5 bits, idle > 5000 clk -> one frame_err pulse; following frame 0x1C received as 8'h1C.
REQ-032 clrn pulsed low after 4 bits of a frame, then full frame 0x24 -> data=8'h24, ready=1, overflow=0.
